// File: rtl/tristate_arb_pkg.sv
// rtl/tristate_arb_pkg.sv - shared types, defaults and sizing helper for the tri-state bus arbiter
//
// Purpose : FSM state encoding, default parameter values and the width
//           function for the turnaround/hold counter.
// Ports   : none (package).
package tristate_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_TURN_CYC = 1;
  localparam int DEF_HOLD_MAX = 8;

  // One spare bit so the counter never wraps before reaching either limit.
  function automatic int cnt_width(input int turn_cyc, input int hold_max);
    int m;
    m = (turn_cyc > hold_max) ? turn_cyc : hold_max;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// rtl/tristate_bus_arbiter_rr_pick.sv - combinational round-robin winner picker
//
// Purpose : returns the first asserted request scanning i_ptr, i_ptr+1, ...
//           modulo N.
// Ports   : i_req   [N-1:0] request vector
//           i_ptr   [W-1:0] scan start index (must be < N)
//           o_idx   [W-1:0] winning index (0 when none)
//           o_valid         high when any request is asserted
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  int w_j;

  // Scan from the far end back toward i_ptr so the last match written is
  // the nearest one to the pointer; avoids an early-exit loop.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = (int'(i_ptr) + k) % N;
      if (i_req[w_j]) begin
        o_idx   = W'(w_j);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - break-before-make round-robin arbiter for a shared tri-state bus
//
// Purpose : grants one requester at a time, waits TURN_CYC cycles before
//           enabling its switch-level driver, and inserts dead cycles
//           between owners.
// Macro   : ARB_TIMEOUT_EN - when defined, drv_en is forced low after
//           HOLD_MAX cycles and o_timeout pulses; otherwise o_timeout is 0.
// Ports   : i_clk                clock, rising edge
//           i_rst                synchronous active-high reset
//           i_req       [N-1:0]  level request per agent
//           i_done      [N-1:0]  release pulse; only the owner bit counts
//           o_grant     [N-1:0]  registered one-hot/zero grant
//           o_drv_en    [N-1:0]  registered one-hot/zero driver enable
//           o_owner_idx [W-1:0]  current or last owner
//           o_busy               high while grant is non-zero
//           o_timeout            one-cycle pulse on forced release
module tristate_bus_arbiter
  import tristate_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int TURN_CYC = DEF_TURN_CYC,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_done,
  output logic [N_REQ-1:0]         o_grant,
  output logic [N_REQ-1:0]         o_drv_en,
  output logic [$clog2(N_REQ)-1:0] o_owner_idx,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int W  = $clog2(N_REQ);
  localparam int CW = cnt_width(TURN_CYC, HOLD_MAX);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYC - 1);
`ifdef ARB_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
`endif

  state_t           r_state, w_state;
  logic [N_REQ-1:0] r_grant, w_grant;
  logic [N_REQ-1:0] r_drv_en, w_drv_en;
  logic [W-1:0]     r_owner, w_owner;
  logic             r_busy, w_busy;
  logic             r_timeout, w_timeout;
  logic [W-1:0]     r_ptr, w_ptr;
  logic [CW-1:0]    r_cnt, w_cnt;

  logic [W-1:0]     w_pick_idx;
  logic             w_pick_valid;
  logic [W-1:0]     w_ptr_after_owner;
  logic             w_hold_hit;
  logic             w_release;

  rr_pick #(
    .N(N_REQ),
    .W(W)
  ) u_rr_pick (
    .i_req  (i_req),
    .i_ptr  (r_ptr),
    .o_idx  (w_pick_idx),
    .o_valid(w_pick_valid)
  );

  // Priority rotates to the agent just after whoever last held the grant.
  assign w_ptr_after_owner = (r_owner == W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef ARB_TIMEOUT_EN
  assign w_hold_hit = (r_state == ST_OWN) && (r_cnt == HOLD_LAST);
`else
  assign w_hold_hit = 1'b0;
`endif

  assign w_release = i_done[r_owner] || !i_req[r_owner] || w_hold_hit;

  always_comb begin
    w_state   = r_state;
    w_grant   = r_grant;
    w_drv_en  = r_drv_en;
    w_owner   = r_owner;
    w_busy    = r_busy;
    w_timeout = 1'b0;
    w_ptr     = r_ptr;
    w_cnt     = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant             = '0;
          w_grant[w_pick_idx] = 1'b1;
          w_owner             = w_pick_idx;
          w_busy              = 1'b1;
          w_cnt               = '0;
          w_state             = ST_TURN;
        end
      end
      ST_TURN: begin
        // Driver stays off here; an owner that drops req aborts before driving.
        if (!i_req[r_owner]) begin
          w_grant = '0;
          w_busy  = 1'b0;
          w_ptr   = w_ptr_after_owner;
          w_state = ST_IDLE;
        end else if (r_cnt == TURN_LAST) begin
          w_drv_en = r_grant;
          w_cnt    = '0;
          w_state  = ST_OWN;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_OWN: begin
        if (w_release) begin
          w_grant   = '0;
          w_drv_en  = '0;
          w_busy    = 1'b0;
          w_ptr     = w_ptr_after_owner;
          w_timeout = w_hold_hit;
          w_state   = ST_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_grant  = '0;
        w_drv_en = '0;
        w_busy   = 1'b0;
        w_state  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_drv_en  <= '0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_grant   <= w_grant;
      r_drv_en  <= w_drv_en;
      r_owner   <= w_owner;
      r_busy    <= w_busy;
      r_timeout <= w_timeout;
      r_ptr     <= w_ptr;
      r_cnt     <= w_cnt;
    end
  end

  assign o_grant     = r_grant;
  assign o_drv_en    = r_drv_en;
  assign o_owner_idx = r_owner;
  assign o_busy      = r_busy;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - directed scoreboard bench for tristate_bus_arbiter
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [3:0] drv_en;
  logic [1:0] owner_idx;
  logic       busy;
  logic       timeout;

  int n_total;
  int n_fail;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic [3:0] d;
    logic [1:0] o;
    logic       b;
    logic       t;
  } exp_t;

  exp_t sb[$];

  tristate_bus_arbiter #(
    .N_REQ   (4),
    .TURN_CYC(1),
    .HOLD_MAX(8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_done     (done),
    .o_grant    (grant),
    .o_drv_en   (drv_en),
    .o_owner_idx(owner_idx),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [3:0] got, input logic [3:0] want);
    n_total++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, field, got, want);
    end
  endtask

  // Expected outputs for the coming edge go into the scoreboard as the
  // stimulus is applied; they are popped and compared just after the edge.
  task automatic tick(input string tag, input logic [3:0] g, input logic [3:0] d,
                      input logic [1:0] o, input logic b, input logic t);
    exp_t e;
    e.tag = tag; e.g = g; e.d = d; e.o = o; e.b = b; e.t = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "grant", grant, e.g);
    chk(e.tag, "drv_en", drv_en, e.d);
    chk(e.tag, "owner_idx", {2'b00, owner_idx}, {2'b00, e.o});
    chk(e.tag, "busy", {3'b000, busy}, {3'b000, e.b});
    chk(e.tag, "timeout", {3'b000, timeout}, {3'b000, e.t});
    chk(e.tag, "one_driver", {3'b000, ($countones(drv_en) <= 1)}, 4'b0001);
    chk(e.tag, "drv_in_grant", drv_en & ~grant, 4'b0000);
  endtask

  initial begin
    logic [3:0] oh;
    logic [1:0] ix;
    n_total = 0;
    n_fail  = 0;
    rst  = 1'b1;
    req  = 4'b1111;
    done = 4'b0000;
    #1;

    // Reset held with all requests up
    tick("rst0", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    tick("rst1", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick("post_rst_grant", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
    tick("post_rst_drv",   4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 4'b0001;
    tick("post_rst_done",  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 4'b0000;
    req  = 4'b0000;
    tick("idle0",          4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester
    req = 4'b0100;
    tick("single_grant", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
    tick("single_drv",   4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    tick("single_hold",  4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 4'b0100;
    tick("single_rel",   4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    done = 4'b0000;
    req  = 4'b0000;
    tick("single_idle",  4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Fairness from a freshly reset pointer
    rst = 1'b1;
    tick("fair_rst", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      ix = 2'(k % 4);
      oh = 4'b0001 << ix;
      tick("fair_grant", oh, 4'b0000, ix, 1'b1, 1'b0);
      tick("fair_drv0",  oh, oh,      ix, 1'b1, 1'b0);
      tick("fair_drv1",  oh, oh,      ix, 1'b1, 1'b0);
      tick("fair_drv2",  oh, oh,      ix, 1'b1, 1'b0);
      done = oh;
      tick("fair_dead",  4'b0000, 4'b0000, ix, 1'b0, 1'b0);
      done = 4'b0000;
    end
    req = 4'b0000;
    tick("fair_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single persistent requester: hold limit behaviour
    req = 4'b0001;
    tick("hold_grant", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
    tick("hold_drv",   4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 7; k++)
      tick("hold_on", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    tick("hold_timeout", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    tick("hold_regrant", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick("hold_abort",   4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    for (int k = 0; k < 11; k++)
      tick("hold_on", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick("hold_reqdrop", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    // Abort during turnaround, then done on a non-owner bit
    req = 4'b0110;
    tick("abort_grant",  4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    req = 4'b0100;
    tick("abort_drop",   4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    tick("abort_next",   4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
    tick("abort_drv",    4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 4'b0100;
    tick("abort_rel",    4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    done = 4'b0000;
    req  = 4'b0010;
    tick("ign_grant",    4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    tick("ign_drv",      4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 4'b1000;
    tick("ign_done3",    4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 4'b0000;
    req  = 4'b1000;
    tick("ign_reqdrop",  4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Reset while agent 3 is driving
    tick("mid_grant",    4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0);
    tick("mid_drv",      4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    rst = 1'b1;
    tick("mid_rst",      4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'b1001;
    tick("mid_ptr0",     4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
    tick("mid_drv0",     4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick("mid_end",      4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
